// File: rtl/safe_lockout_ctrl.sv
// Door-latch and wrong-code lockout sequencer behind the safe's code-check FSM.
// Optional tamper alarm is included when SAFE_ALARM_EN is defined.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | verdicts accepted, entry_en high
// OPEN    | door latch driven for OPEN_CYCLES cycles
// LOCKOUT | entry blocked for LOCKOUT_CYCLES cycles after MAX_FAILS fails
module safe_lockout_ctrl #(
    parameter int MAX_FAILS      = 3,
    parameter int OPEN_CYCLES    = 8,
    parameter int LOCKOUT_CYCLES = 16
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           unlock_valid,
    input  logic                           unlock,
    input  logic                           incorrect,
`ifdef SAFE_ALARM_EN
    input  logic                           alarm_ack,
    output logic                           alarm,
`endif
    output logic                           entry_en,
    output logic                           door_open,
    output logic                           locked_out,
    output logic [$clog2(MAX_FAILS+1)-1:0] fail_cnt,
    output logic [7:0]                     lockout_total
);

    localparam int FW    = $clog2(MAX_FAILS + 1);
    localparam int T_MAX = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
    // Clamp to one bit so the single-cycle windows still elaborate.
    localparam int TW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    localparam logic [FW-1:0] FAIL_LAST = FW'(MAX_FAILS - 1);
    localparam logic [TW-1:0] OPEN_LOAD = TW'(OPEN_CYCLES - 1);
    localparam logic [TW-1:0] LOCK_LOAD = TW'(LOCKOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OPEN    = 2'd1,
        LOCKOUT = 2'd2
    } state_t;

    state_t          state;
    logic [TW-1:0]   timer;
    logic            pass_v;
    logic            fail_v;
    logic            lock_entry;

    assign pass_v     = unlock_valid & unlock;
    assign fail_v     = unlock_valid & ~unlock & incorrect;
    assign lock_entry = (state == IDLE) & fail_v & (fail_cnt == FAIL_LAST);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= IDLE;
            timer         <= '0;
            fail_cnt      <= '0;
            lockout_total <= 8'd0;
            entry_en      <= 1'b1;
            door_open     <= 1'b0;
            locked_out    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pass_v) begin
                        state     <= OPEN;
                        fail_cnt  <= '0;
                        timer     <= OPEN_LOAD;
                        entry_en  <= 1'b0;
                        door_open <= 1'b1;
                    end else if (fail_v) begin
                        if (fail_cnt == FAIL_LAST) begin
                            state      <= LOCKOUT;
                            fail_cnt   <= '0;
                            timer      <= LOCK_LOAD;
                            entry_en   <= 1'b0;
                            locked_out <= 1'b1;
                            if (lockout_total != 8'hFF)
                                lockout_total <= lockout_total + 8'd1;
                        end else begin
                            fail_cnt <= fail_cnt + 1'b1;
                        end
                    end
                end
                OPEN, LOCKOUT: begin
                    // Verdicts are ignored here; only the window timer runs.
                    if (timer == '0) begin
                        state      <= IDLE;
                        entry_en   <= 1'b1;
                        door_open  <= 1'b0;
                        locked_out <= 1'b0;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    timer      <= '0;
                    entry_en   <= 1'b1;
                    door_open  <= 1'b0;
                    locked_out <= 1'b0;
                end
            endcase
        end
    end

`ifdef SAFE_ALARM_EN
    // Sticky past lockout expiry; a new lockout beats a same-cycle ack.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            alarm <= 1'b0;
        else if (lock_entry)
            alarm <= 1'b1;
        else if (alarm_ack)
            alarm <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_safe_lockout_ctrl.sv
// Scoreboard bench for safe_lockout_ctrl: a behavioural model queues the
// expected post-edge outputs for each driven cycle, compared after the edge.
module tb_safe_lockout_ctrl;

    localparam int MAX_FAILS      = 3;
    localparam int OPEN_CYCLES    = 8;
    localparam int LOCKOUT_CYCLES = 16;
    localparam int FW             = $clog2(MAX_FAILS + 1);

    logic          clk = 1'b0;
    logic          rstn;
    logic          unlock_valid, unlock, incorrect;
    logic          alarm_ack;
    logic          alarm_w;
    logic          entry_en, door_open, locked_out;
    logic [FW-1:0] fail_cnt;
    logic [7:0]    lockout_total;

    safe_lockout_ctrl #(
        .MAX_FAILS     (MAX_FAILS),
        .OPEN_CYCLES   (OPEN_CYCLES),
        .LOCKOUT_CYCLES(LOCKOUT_CYCLES)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .unlock_valid (unlock_valid),
        .unlock       (unlock),
        .incorrect    (incorrect),
`ifdef SAFE_ALARM_EN
        .alarm_ack    (alarm_ack),
        .alarm        (alarm_w),
`endif
        .entry_en     (entry_en),
        .door_open    (door_open),
        .locked_out   (locked_out),
        .fail_cnt     (fail_cnt),
        .lockout_total(lockout_total)
    );

`ifndef SAFE_ALARM_EN
    assign alarm_w = 1'b0;
`endif

    always #5 clk = ~clk;

    typedef struct {
        logic          en;
        logic          door;
        logic          lock;
        logic [FW-1:0] fc;
        logic [7:0]    tot;
        logic          alarm;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    // model state: mode 0=idle 1=open 2=lockout, rem = cycles left high
    int          m_mode, m_rem, m_fail, m_tot;
    logic        m_alarm;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_mode = 0; m_rem = 0; m_fail = 0; m_tot = 0; m_alarm = 1'b0;
    endtask

    task automatic model_step(input logic uv, input logic u, input logic inc, input logic ack);
        logic set_alarm;
        exp_t e;
        set_alarm = 1'b0;
        if (m_mode == 0) begin
            if (uv && u) begin
                m_mode = 1; m_rem = OPEN_CYCLES; m_fail = 0;
            end else if (uv && inc) begin
                if (m_fail + 1 == MAX_FAILS) begin
                    m_mode = 2; m_rem = LOCKOUT_CYCLES; m_fail = 0;
                    if (m_tot < 255) m_tot++;
                    set_alarm = 1'b1;
                end else begin
                    m_fail++;
                end
            end
        end else begin
            m_rem--;
            if (m_rem == 0) m_mode = 0;
        end
        if (set_alarm) m_alarm = 1'b1;
        else if (ack)  m_alarm = 1'b0;
        e.en    = (m_mode == 0);
        e.door  = (m_mode == 1);
        e.lock  = (m_mode == 2);
        e.fc    = FW'(m_fail);
        e.tot   = 8'(m_tot);
        e.alarm = m_alarm;
        sb.push_back(e);
    endtask

    task automatic step(input logic uv, input logic u, input logic inc, input logic ack);
        exp_t e;
        unlock_valid = uv; unlock = u; incorrect = inc; alarm_ack = ack;
        model_step(uv, u, inc, ack);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("entry_en",      32'(entry_en),      32'(e.en));
            chk("door_open",     32'(door_open),     32'(e.door));
            chk("locked_out",    32'(locked_out),    32'(e.lock));
            chk("fail_cnt",      32'(fail_cnt),      32'(e.fc));
            chk("lockout_total", 32'(lockout_total), 32'(e.tot));
`ifdef SAFE_ALARM_EN
            chk("alarm",         32'(alarm_w),       32'(e.alarm));
`endif
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_entry_en"},   32'(entry_en),      32'd1);
        chk({tag, "_door_open"},  32'(door_open),     32'd0);
        chk({tag, "_locked_out"}, 32'(locked_out),    32'd0);
        chk({tag, "_fail_cnt"},   32'(fail_cnt),      32'd0);
        chk({tag, "_total"},      32'(lockout_total), 32'd0);
        chk({tag, "_alarm"},      32'(alarm_w),       32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        rstn = 1'b0; unlock_valid = 1'b0; unlock = 1'b0; incorrect = 1'b0; alarm_ack = 1'b0;
        model_reset();
        #12;
        check_reset_outputs("reset");
        @(posedge clk); #2 rstn = 1'b1;

        idle(2);
        // PASS: door for exactly OPEN_CYCLES, then idle
        step(1'b1, 1'b1, 1'b0, 1'b0);
        idle(OPEN_CYCLES + 1);

        // FAIL, FAIL, then PASS clears the count
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        // wrong verdict during OPEN is dropped
        step(1'b1, 1'b0, 1'b1, 1'b0);
        idle(OPEN_CYCLES);

        // three FAILs -> lockout; PASS during lockout ignored
        for (int i = 0; i < MAX_FAILS; i++) step(1'b1, 1'b0, 1'b1, 1'b0);
        idle(3);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        idle(LOCKOUT_CYCLES);
        // alarm (if present) survives expiry until acked
        idle(2);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        idle(1);

        // both verdict bits -> PASS; strobes without unlock_valid do nothing
        step(1'b1, 1'b1, 1'b1, 1'b0);
        idle(OPEN_CYCLES + 1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);

        // second lockout with ack on the entering edge: set must win
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        idle(LOCKOUT_CYCLES + 1);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // randomised verdict traffic
        for (int i = 0; i < 300; i++) begin
            logic uv, u, inc, ack;
            uv  = ($urandom_range(0, 2) == 0);
            u   = ($urandom_range(0, 3) == 0);
            inc = ($urandom_range(0, 1) == 0);
            ack = ($urandom_range(0, 7) == 0);
            step(uv, u, inc, ack);
        end

        // asynchronous reset in the middle of OPEN
        idle(LOCKOUT_CYCLES + 2);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        idle(3);
        #2 rstn = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        model_reset();
        @(posedge clk); #2 rstn = 1'b1;
        idle(2);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
